// File: rtl/max_tree_pipe.sv
// max_tree_pipe: pipelined reduction of CHANNELS operands to one extreme value
// (maximum or minimum, signed or unsigned) plus the lane index it came from.
//
// Each level of the binary comparator tree is one register stage, so a beat
// leaves STAGES = clog2(CHANNELS) cycles after it is accepted when the output
// is not stalled. The mode bits travel with every beat. Each stage has its own
// valid bit, and a stage refills whenever the stage after it moves. This keeps
// full throughput and removes bubbles while the output is stalled.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_data               packed operands, lane k at [k*WIDTH +: WIDTH]
//   in_mask               1 = lane takes part in the reduction
//   in_min                0 = select maximum, 1 = select minimum
//   in_signed             1 = two's-complement compare
//   out_valid / out_ready output handshake
//   out_data, out_idx     selected value and its lane index
//   out_none              every lane of the beat was masked (data/idx are 0)
module max_tree_pipe #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int IDXW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_mask,
    input  logic                      in_min,
    input  logic                      in_signed,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDXW-1:0]           out_idx,
    output logic                      out_none
);

    localparam int STAGES = $clog2(CHANNELS);

    // Number of nodes at a tree level (level 0 = the input lanes).
    function automatic int lvl_cnt(input int lvl);
        int n;
        n = CHANNELS;
        for (int k = 0; k < lvl; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // True when the left (lower-index) child should win. Flipping the MSB
    // turns a two's-complement compare into an unsigned one. Because of the
    // equality terms, ties go to the lower index in both modes.
    function automatic logic left_wins(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic mn, input logic sg);
        logic [WIDTH-1:0] flip;
        logic [WIDTH-1:0] ka;
        logic [WIDTH-1:0] kb;
        flip            = '0;
        flip[WIDTH-1]   = sg;
        ka              = a ^ flip;
        kb              = b ^ flip;
        return mn ? (ka <= kb) : (ka >= kb);
    endfunction

    // Registered node state for each stage; stage s holds tree level s.
    logic [WIDTH-1:0] node_val  [1:STAGES][0:CHANNELS-1];
    logic [IDXW-1:0]  node_idx  [1:STAGES][0:CHANNELS-1];
    logic             node_flag [1:STAGES][0:CHANNELS-1];
    logic [STAGES:1]  stage_vld;
    logic [STAGES:1]  stage_min;
    logic [STAGES:1]  stage_sgn;

    // Combinational next values feeding each stage.
    logic [WIDTH-1:0] nxt_val   [1:STAGES][0:CHANNELS-1];
    logic [IDXW-1:0]  nxt_idx   [1:STAGES][0:CHANNELS-1];
    logic             nxt_flag  [1:STAGES][0:CHANNELS-1];
    logic [STAGES:1]  src_vld;
    logic [STAGES:1]  src_min;
    logic [STAGES:1]  src_sgn;
    logic [STAGES+1:1] load;

    assign load[STAGES+1] = out_ready;

    generate
        for (genvar gi = 1; gi <= STAGES; gi++) begin : g_stage
            localparam int NIN  = lvl_cnt(gi - 1);
            localparam int NOUT = lvl_cnt(gi);

            if (gi == 1) begin : g_src_in
                assign src_vld[gi] = in_valid;
                assign src_min[gi] = in_min;
                assign src_sgn[gi] = in_signed;
            end else begin : g_src_reg
                assign src_vld[gi] = stage_vld[gi-1];
                assign src_min[gi] = stage_min[gi-1];
                assign src_sgn[gi] = stage_sgn[gi-1];
            end

            // A stage loads when it is empty or its contents move on.
            assign load[gi] = ~stage_vld[gi] | load[gi+1];

            for (genvar gj = 0; gj < CHANNELS; gj++) begin : g_node
                if (gj < NOUT) begin : g_live
                    logic [WIDTH-1:0] l_val;
                    logic [WIDTH-1:0] r_val;
                    logic [IDXW-1:0]  l_idx;
                    logic [IDXW-1:0]  r_idx;
                    logic             l_flag;
                    logic             r_flag;
                    logic             pick_l;
                    logic             pick_r;

                    if (gi == 1) begin : g_leaf
                        assign l_val  = in_data[2*gj*WIDTH +: WIDTH];
                        assign l_idx  = IDXW'(2*gj);
                        assign l_flag = in_mask[2*gj];
                        if (2*gj + 1 < NIN) begin : g_pair
                            assign r_val  = in_data[(2*gj+1)*WIDTH +: WIDTH];
                            assign r_idx  = IDXW'(2*gj + 1);
                            assign r_flag = in_mask[2*gj+1];
                        end else begin : g_odd
                            // An odd lane out faces an empty partner, so it
                            // passes through unchanged.
                            assign r_val  = '0;
                            assign r_idx  = '0;
                            assign r_flag = 1'b0;
                        end
                    end else begin : g_inner
                        assign l_val  = node_val[gi-1][2*gj];
                        assign l_idx  = node_idx[gi-1][2*gj];
                        assign l_flag = node_flag[gi-1][2*gj];
                        if (2*gj + 1 < NIN) begin : g_pair
                            assign r_val  = node_val[gi-1][2*gj+1];
                            assign r_idx  = node_idx[gi-1][2*gj+1];
                            assign r_flag = node_flag[gi-1][2*gj+1];
                        end else begin : g_odd
                            assign r_val  = '0;
                            assign r_idx  = '0;
                            assign r_flag = 1'b0;
                        end
                    end

                    assign pick_l = l_flag & (~r_flag | left_wins(l_val, r_val, src_min[gi], src_sgn[gi]));
                    assign pick_r = r_flag & ~pick_l;

                    assign nxt_val[gi][gj]  = pick_l ? l_val : (pick_r ? r_val : '0);
                    assign nxt_idx[gi][gj]  = pick_l ? l_idx : (pick_r ? r_idx : '0);
                    assign nxt_flag[gi][gj] = l_flag | r_flag;
                end else begin : g_dead
                    assign nxt_val[gi][gj]  = '0;
                    assign nxt_idx[gi][gj]  = '0;
                    assign nxt_flag[gi][gj] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld <= '0;
            stage_min <= '0;
            stage_sgn <= '0;
            for (int s = 1; s <= STAGES; s++) begin
                for (int j = 0; j < CHANNELS; j++) begin
                    node_val[s][j]  <= '0;
                    node_idx[s][j]  <= '0;
                    node_flag[s][j] <= 1'b0;
                end
            end
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                if (load[s]) begin
                    stage_vld[s] <= src_vld[s];
                    // Payload changes only for real beats, so a bubble never
                    // disturbs the registers.
                    if (src_vld[s]) begin
                        stage_min[s] <= src_min[s];
                        stage_sgn[s] <= src_sgn[s];
                        for (int j = 0; j < CHANNELS; j++) begin
                            node_val[s][j]  <= nxt_val[s][j];
                            node_idx[s][j]  <= nxt_idx[s][j];
                            node_flag[s][j] <= nxt_flag[s][j];
                        end
                    end
                end
            end
        end
    end

    assign in_ready  = load[1];
    assign out_valid = stage_vld[STAGES];
    assign out_data  = node_val[STAGES][0];
    assign out_idx   = node_idx[STAGES][0];
    // Gated with valid so that out_none reads 0 after reset.
    assign out_none  = stage_vld[STAGES] & ~node_flag[STAGES][0];

endmodule

// File: tb/tb_max_tree_pipe.sv
// Testbench for max_tree_pipe. It runs two instances, CHANNELS=4 (dut 0) and
// CHANNELS=5 (dut 1). Expected results come from a lane-by-lane reference scan.
// They go into a per-dut queue when a beat is accepted. A monitor per dut pops
// an entry and compares it each time a result transfers.
module tb_max_tree_pipe;

    typedef struct {
        logic [7:0] val;
        int         idx;
        bit         none;
        int         cyc;
        bit         cl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        ivld  [2];
    logic        irdy  [2];
    logic        imin  [2];
    logic        isgn  [2];
    logic        ov    [2];
    logic        ordy  [2];
    logic        onone [2];
    logic [39:0] idata [2];
    logic [4:0]  imask [2];
    logic [7:0]  od    [2];
    logic [1:0]  oidx0;
    logic [2:0]  oidx1;

    bit saw_block [2];
    bit rdone     [2];

    int total = 0;
    int bad   = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    max_tree_pipe #(.CHANNELS(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(ivld[0]), .in_ready(irdy[0]),
        .in_data(idata[0][31:0]), .in_mask(imask[0][3:0]),
        .in_min(imin[0]), .in_signed(isgn[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od[0]), .out_idx(oidx0), .out_none(onone[0])
    );

    max_tree_pipe #(.CHANNELS(5), .WIDTH(8)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(ivld[1]), .in_ready(irdy[1]),
        .in_data(idata[1]), .in_mask(imask[1]),
        .in_min(imin[1]), .in_signed(isgn[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od[1]), .out_idx(oidx1), .out_none(onone[1])
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_idx(input int g);
        return (g == 0) ? int'(oidx0) : int'(oidx1);
    endfunction

    function automatic void sb_push(input int g, input exp_t e);
        if (g == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    function automatic exp_t sb_pop(input int g);
        if (g == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    function automatic int sb_size(input int g);
        return (g == 0) ? sb0.size() : sb1.size();
    endfunction

    // Reference: scan the lanes in order and keep a lane only if it is
    // strictly better than the current best, so ties go to the lower index.
    function automatic exp_t ref_model(input int ch, input logic [39:0] d, input logic [4:0] m,
                                       input logic mn, input logic sg);
        exp_t       e;
        int         best;
        int         bv;
        int         v;
        logic [7:0] lane;
        best = -1;
        bv   = 0;
        for (int k = 0; k < ch; k++) begin
            if (m[k]) begin
                lane = d[k*8 +: 8];
                v    = sg ? int'($signed(lane)) : int'(lane);
                if (best < 0 || (mn ? (v < bv) : (v > bv))) begin
                    best = k;
                    bv   = v;
                end
            end
        end
        e.none = (best < 0);
        e.val  = 8'h00;
        e.idx  = 0;
        if (best >= 0) begin
            e.val = d[best*8 +: 8];
            e.idx = best;
        end
        e.cyc = 0;
        e.cl  = 1'b0;
        return e;
    endfunction

    // Offer one beat to dut g. The task returns just after the accepting edge.
    task automatic send(input int g, input logic [39:0] d, input logic [4:0] m,
                        input logic mn, input logic sg, input bit cl);
        exp_t e;
        bit   done;
        done = 1'b0;
        e    = ref_model((g == 0) ? 4 : 5, d, m, mn, sg);
        e.cl = cl;
        @(negedge clk);
        ivld[g]  = 1'b1;
        idata[g] = d;
        imask[g] = m;
        imin[g]  = mn;
        isgn[g]  = sg;
        for (int t = 0; t < 100 && !done; t++) begin
            #1;
            if (irdy[g]) begin
                e.cyc = cyc;
                sb_push(g, e);
                done = 1'b1;
                @(posedge clk);
            end else begin
                saw_block[g] = 1'b1;
                @(negedge clk);
            end
        end
        if (!done) begin
            check("accept_timeout", 0, 1);
            ivld[g] = 1'b0;
        end
    endtask

    task automatic drop(input int g);
        @(negedge clk);
        ivld[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        for (int t = 0; t < 300 && sb_size(g) != 0; t++) @(negedge clk);
        if (sb_size(g) != 0) check("drain_timeout", sb_size(g), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_phase(input int g, input int n);
        rdone[g] = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(negedge clk);
                        ivld[g] = 1'b0;
                    end
                    send(g, 40'({$urandom, $urandom}), 5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
                drop(g);
                rdone[g] = 1'b1;
            end
            begin
                while (!rdone[g]) begin
                    @(negedge clk);
                    ordy[g] = ($urandom_range(0, 3) != 0);
                end
                ordy[g] = 1'b1;
            end
        join
        drain(g);
    endtask

    // Monitors sample one time unit before each rising edge. A result that is
    // valid with out_ready high transfers at that edge.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        exp_t       e;
        bit         held;
        logic [7:0] hd;
        int         hi;
        logic       hn;
        initial begin
            held = 1'b0;
            forever begin
                @(negedge clk);
                #4;
                if (rst) begin
                    held = 1'b0;
                end else begin
                    if (held && ov[g]) begin
                        check("hold_data", int'(od[g]), int'(hd));
                        check("hold_idx", get_idx(g), hi);
                        check("hold_none", int'(onone[g]), int'(hn));
                    end
                    if (ov[g] && ordy[g]) begin
                        held = 1'b0;
                        $display("dut%0d out data=%0d idx=%0d none=%0d", g, od[g], get_idx(g), onone[g]);
                        if (sb_size(g) == 0) begin
                            check("unexpected_beat", 1, 0);
                        end else begin
                            e = sb_pop(g);
                            check("out_data", int'(od[g]), int'(e.val));
                            check("out_idx", get_idx(g), e.idx);
                            check("out_none", int'(onone[g]), int'(e.none));
                            if (e.cl) check("latency", cyc - e.cyc, (g == 0) ? 2 : 3);
                        end
                    end else if (ov[g]) begin
                        held = 1'b1;
                        hd   = od[g];
                        hi   = get_idx(g);
                        hn   = onone[g];
                    end else begin
                        held = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    bit pat [4];

    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int g = 0; g < 2; g++) begin
            ivld[g]  = 1'b0;
            idata[g] = '0;
            imask[g] = '0;
            imin[g]  = 1'b0;
            isgn[g]  = 1'b0;
            ordy[g]  = 1'b1;
            saw_block[g] = 1'b0;
            rdone[g] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("reset_out_valid", int'(ov[g]), 0);
            check("reset_out_data", int'(od[g]), 0);
            check("reset_out_idx", get_idx(g), 0);
            check("reset_out_none", int'(onone[g]), 0);
            check("reset_in_ready", int'(irdy[g]), 1);
        end

        // Directed beats on CHANNELS=4, sent back to back.
        send(0, {8'd0, 8'd2, 8'd9, 8'd9, 8'd3}, 5'b01111, 1'b0, 1'b0, 1'b1);
        send(0, {8'd0, 8'hFF, 8'h00, 8'h7F, 8'h80}, 5'b01111, 1'b1, 1'b1, 1'b1);
        send(0, {8'd0, 8'hFF, 8'h00, 8'h7F, 8'h80}, 5'b01111, 1'b0, 1'b0, 1'b1);
        send(0, {8'd0, 8'd4, 8'd8, 8'd6, 8'd1}, 5'b00000, 1'b0, 1'b0, 1'b1);
        send(0, {8'd0, 8'd7, 8'd5, 8'd9, 8'd1}, 5'b00100, 1'b0, 1'b0, 1'b1);
        drop(0);
        drain(0);

        // Streaming: six beats while out_ready cycles 1,0,0,1.
        saw_block[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(0, 40'({$urandom, $urandom}), 5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
                drop(0);
            end
            begin
                for (int k = 0; k < 24; k++) begin
                    @(negedge clk);
                    ordy[0] = pat[k % 4];
                end
                ordy[0] = 1'b1;
            end
        join
        check("in_ready_deassert", int'(saw_block[0]), 1);
        drain(0);

        // CHANNELS=5: the odd lane 4 holds the maximum.
        send(1, {8'd200, 8'd3, 8'd199, 8'd50, 8'd10}, 5'b11111, 1'b0, 1'b0, 1'b1);
        drop(1);
        drain(1);

        // Random traffic with random back-pressure on both trees.
        fork
            rand_phase(0, 150);
            rand_phase(1, 150);
        join

        // Reset while two beats are in flight: neither may emerge.
        ordy[1] = 1'b0;
        send(1, 40'({$urandom, $urandom}), 5'b11111, 1'b0, 1'b0, 1'b0);
        send(1, 40'({$urandom, $urandom}), 5'b11111, 1'b1, 1'b0, 1'b0);
        drop(1);
        repeat (4) @(negedge clk);
        #1;
        check("pre_reset_valid", int'(ov[1]), 1);
        #1;
        rst = 1'b1;
        #1;
        check("reset_mid_valid", int'(ov[1]), 0);
        check("reset_mid_data", int'(od[1]), 0);
        sb1.delete();
        ordy[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("post_reset_idle", int'(ov[1]), 0);
        send(1, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 5'b11111, 1'b0, 1'b0, 1'b1);
        drop(1);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
